// File: rtl/wavelet_2d_multilevel.sv
// In-place multilevel 2D integer Haar (S-transform) lifting engine for an N x N frame
// held in an external simple-dual-port RAM; one line is buffered, transformed and written back.
module wavelet_2d_multilevel #(
  parameter int DATA_W     = 16,
  parameter int LOG2_N     = 6,
  parameter int MAX_LEVELS = 3,
  parameter int LVL_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LVL_W-1:0]      levels_cfg,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_flag,
  output logic                  rd_en,
  output logic [2*LOG2_N-1:0]   rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  wr_en,
  output logic [2*LOG2_N-1:0]   wr_addr,
  output logic [DATA_W-1:0]     wr_data
);

  localparam int N  = 1 << LOG2_N;
  localparam int AW = 2 * LOG2_N;
  localparam logic [LVL_W-1:0]  MAX_L = LVL_W'(MAX_LEVELS);
  localparam logic [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LVL_W-1:0]    levels_q, levels_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic                pass_q, pass_d;      // 0: row pass, 1: column pass
  logic [LOG2_N-1:0]   line_q, line_d;
  logic [LOG2_N-1:0]   elem_q, elem_d;
  logic                sat_q, sat_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic [DATA_W-1:0]   line_buf_q [N];

  logic [LVL_W-1:0]    cfg_lim;
  logic [LOG2_N-1:0]   m_last;              // M-1 for the current level
  logic [LOG2_N-1:0]   m_half;              // M/2 for the current level
  logic [AW-1:0]       addr_next;
  logic                is_detail;
  logic [LOG2_N-1:0]   pair_k;
  logic [LOG2_N-1:0]   idx_a, idx_b;
  logic signed [DATA_W-1:0] op_a, op_b;
  logic signed [DATA_W:0]   a_ext, b_ext, d_full, s_full;
  logic                d_ovf;
  logic [DATA_W-1:0]   d_sat;
  logic                buf_we;
  logic [LOG2_N-1:0]   buf_idx;

  assign cfg_lim = (levels_cfg > MAX_L) ? MAX_L : levels_cfg;
  assign m_last  = {LOG2_N{1'b1}} >> lvl_q;
  assign m_half  = (m_last >> 1) + LOG2_N'(1);

  // Sequencing: line -> pass -> level -> done.
  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    levels_d = levels_q;
    lvl_d    = lvl_q;
    pass_d   = pass_q;
    line_d   = line_q;
    elem_d   = elem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          levels_d = cfg_lim;
          lvl_d    = '0;
          pass_d   = 1'b0;
          line_d   = '0;
          elem_d   = '0;
          state_d  = (cfg_lim == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (elem_q == m_last) begin
          elem_d  = '0;
          state_d = S_FLUSH;
        end else begin
          elem_d = elem_q + LOG2_N'(1);
        end
      end
      S_FLUSH: begin
        elem_d  = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (elem_q == m_last) begin
          elem_d  = '0;
          state_d = S_LOAD;
          if (line_q != m_last) begin
            line_d = line_q + LOG2_N'(1);
          end else begin
            line_d = '0;
            if (!pass_q) begin
              pass_d = 1'b1;
            end else begin
              pass_d = 1'b0;
              if (lvl_q == levels_q - LVL_W'(1)) state_d = S_DONE;
              else                               lvl_d   = lvl_q + LVL_W'(1);
            end
          end
        end else begin
          elem_d = elem_q + LOG2_N'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lifting operands for the element about to be written; in FLUSH the last sample is still on rd_data.
  always_comb begin
    is_detail = (elem_d >= m_half);
    pair_k    = is_detail ? (elem_d - m_half) : elem_d;
    idx_a     = pair_k << 1;
    idx_b     = idx_a | LOG2_N'(1);
    op_a      = $signed(line_buf_q[idx_a]);
    op_b      = ((state_q == S_FLUSH) && (idx_b == m_last)) ? $signed(rd_data)
                                                            : $signed(line_buf_q[idx_b]);
    a_ext     = {op_a[DATA_W-1], op_a};
    b_ext     = {op_b[DATA_W-1], op_b};
    d_full    = b_ext - a_ext;
    s_full    = a_ext + (d_full >>> 1);
    d_ovf     = d_full[DATA_W] ^ d_full[DATA_W-1];
    if (d_ovf) d_sat = d_full[DATA_W] ? D_MIN : D_MAX;
    else       d_sat = d_full[DATA_W-1:0];
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_comb begin
    addr_next = pass_d ? {elem_d, line_d} : {line_d, elem_d};
    busy_d    = (state_d == S_LOAD) || (state_d == S_FLUSH) || (state_d == S_WRITE);
    done_d    = (state_d == S_DONE);
    rd_en_d   = (state_d == S_LOAD);
    wr_en_d   = (state_d == S_WRITE);
    rd_addr_d = rd_en_d ? addr_next : '0;
    wr_addr_d = wr_en_d ? addr_next : '0;
    wr_data_d = '0;
    sat_d     = sat_q;
    if (state_q == S_IDLE && start) sat_d = 1'b0;
    if (wr_en_d) begin
      wr_data_d = is_detail ? d_sat : s_full[DATA_W-1:0];
      if (is_detail && d_ovf) sat_d = 1'b1;
    end
  end

  always_comb begin
    buf_we  = 1'b0;
    buf_idx = '0;
    if (state_q == S_LOAD && elem_q != '0) begin
      buf_we  = 1'b1;
      buf_idx = elem_q - LOG2_N'(1);
    end else if (state_q == S_FLUSH) begin
      buf_we  = 1'b1;
      buf_idx = m_last;
    end
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      levels_q  <= '0;
      lvl_q     <= '0;
      pass_q    <= 1'b0;
      line_q    <= '0;
      elem_q    <= '0;
      sat_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      levels_q  <= levels_d;
      lvl_q     <= lvl_d;
      pass_q    <= pass_d;
      line_q    <= line_d;
      elem_q    <= elem_d;
      sat_q     <= sat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // NOTE: the line buffer is not reset; every entry is loaded before it is read, so it maps to plain RAM.
  always_ff @(posedge clk) begin
    if (buf_we) line_buf_q[buf_idx] <= rd_data;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sat_flag = sat_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule
